// File: rtl/tnoc_flit_demux_controller_pkg.sv
// Shared types and helpers for the flit demux/mux controllers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tnoc_flit_demux_controller_pkg;

   localparam int TNOC_DEFAULT_VCS = 2;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } tnoc_demux_ctrl_state_e;

   // True when exactly one bit is set; callers zero-extend narrower vectors.
   function automatic logic tnoc_is_onehot(input logic [31:0] v);
      return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
   endfunction

endpackage

// File: rtl/tnoc_packet_counter.sv
// Saturating completed-packet counter for one demux output.
// Latency: increment visible one cycle after i_inc.
// Backpressure: none; holds at all-ones instead of wrapping.
module tnoc_packet_counter #(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_count
);

   // Count up once per completed packet, sticking at the maximum value.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_count <= '0;
      end else if (i_inc && (o_count != '1)) begin
         o_count <= o_count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/tnoc_flit_demux_controller.sv
// Steers a flit stream to one demux output, holding the route from head to tail.
// Latency: zero-cycle head select from i_route; body/tail use the registered route.
// Backpressure: drives select 0 for unroutable heads so the demux withholds ready.
module tnoc_flit_demux_controller
   import tnoc_flit_demux_controller_pkg::*;
#(
   parameter int CHANNELS      = TNOC_DEFAULT_VCS,
   parameter int ENTRIES       = 2,
   parameter int COUNTER_WIDTH = 16
) (
   input  logic                             i_clk,
   input  logic                             i_rst,
   input  logic [CHANNELS-1:0]              i_valid,
   input  logic [CHANNELS-1:0]              i_ready,
   input  logic                             i_head,
   input  logic                             i_tail,
   input  logic [ENTRIES-1:0]               i_route,
   output logic [ENTRIES-1:0]               o_select,
   output logic                             o_busy,
   output logic                             o_error,
   output logic [ENTRIES*COUNTER_WIDTH-1:0] o_packet_count
);

   tnoc_demux_ctrl_state_e state_q, state_d;
   logic [ENTRIES-1:0]     sel_q;
   logic [CHANNELS-1:0]    vc_q;
   logic                   error_q;

   logic                   any_valid;
   logic                   fire;
   logic                   vc_fire;
   logic                   route_ok;
   logic                   load;
   logic                   err_set;
   logic [ENTRIES-1:0]     inc_vec;

   assign any_valid = |i_valid;
   assign fire      = |(i_valid & i_ready);
   assign vc_fire   = |(i_valid & i_ready & vc_q);
   assign route_ok  = tnoc_is_onehot(32'(i_route));

   // State, latched route/channel and sticky error flag.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         sel_q   <= '0;
         vc_q    <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load) begin
            sel_q <= i_route;
            vc_q  <= i_valid;
         end
         if (err_set) begin
            error_q <= 1'b1;
         end
      end
   end

   // Next state, route capture, packet completion and protocol error detection.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      err_set = 1'b0;
      inc_vec = '0;
      case (state_q)
         IDLE: begin
            if (any_valid && (!i_head || !route_ok)) begin
               err_set = 1'b1;
            end
            if (fire && i_head && route_ok) begin
               if (i_tail) begin
                  inc_vec = i_route;
               end else begin
                  state_d = BUSY;
                  load    = 1'b1;
               end
            end
         end
         BUSY: begin
            // Foreign-channel or stray-head flits are flagged but not blocked.
            if (any_valid && (i_head || (|(i_valid & ~vc_q)))) begin
               err_set = 1'b1;
            end
            if (vc_fire && i_tail) begin
               state_d = IDLE;
               inc_vec = sel_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Select: pass-through for a routable head in IDLE, held route in BUSY.
   always_comb begin
      o_select = '0;
      case (state_q)
         IDLE: begin
            if (any_valid && i_head && route_ok) begin
               o_select = i_route;
            end
         end
         BUSY:    o_select = sel_q;
         default: o_select = '0;
      endcase
   end

   assign o_busy  = (state_q == BUSY);
   assign o_error = error_q;

   for (genvar g = 0; g < ENTRIES; g++) begin : g_cnt
      tnoc_packet_counter #(
         .WIDTH (COUNTER_WIDTH)
      ) u_cnt (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .i_inc   (inc_vec[g]),
         .o_count (o_packet_count[g*COUNTER_WIDTH +: COUNTER_WIDTH])
      );
   end

endmodule

// File: doc/tnoc_flit_demux_controller.md
# tnoc_flit_demux_controller

Sequencing controller for the flit demultiplexer: it generates the one-hot `i_select` that steers one flit stream to one of `ENTRIES` outputs. It latches the route on each head flit and holds it until that packet's tail flit is accepted, so a packet is never split across outputs. It sits between the route computation and the demux, and also keeps per-output packet counters for debug.

## Interface
- `CHANNELS`, default `CONFIG.virtual_channels`: number of virtual channels; width of valid/ready.
- `ENTRIES`, default 2: number of demux outputs; width of select/route.
- `COUNTER_WIDTH`, default 16: width of each per-output packet counter.
- `i_clk`, input, 1: clock.
- `i_rst`, input, 1: reset. One clock; reset is synchronous and active-high.
- `i_valid`, input, CHANNELS: valid at the demux input, at most one bit set.
- `i_ready`, input, CHANNELS: ready returned by the demux (muxed from the selected output).
- `i_head`, input, 1: current flit is a head flit.
- `i_tail`, input, 1: current flit is a tail flit. Head and tail both set means a single-flit packet.
- `i_route`, input, ENTRIES: one-hot destination from route computation. Meaningful only with a head flit.
- `o_select`, output, ENTRIES: one-hot select to the demux.
- `o_busy`, output, 1: a multi-flit packet is in progress.
- `o_error`, output, 1: sticky protocol-error flag.
- `o_packet_count`, output, ENTRIES×COUNTER_WIDTH: completed packets per output, saturating.

## Operation
- Handshake: `fire = |(i_valid & i_ready)`.
- States are IDLE and BUSY.
- IDLE behaviour:
  - With a valid head flit and one-hot `i_route`, `o_select = i_route` combinationally, so the head flit passes with no added latency.
  - Otherwise `o_select = 0`. The demux then returns ready = 0 and the input stalls.
- IDLE transitions:
  - Head fires with tail = 0: latch `i_route` into `sel_q`, latch `i_valid` into `vc_q`, go to BUSY.
  - Head fires with tail = 1: stay IDLE and increment the counter for `i_route`.
- BUSY behaviour: `o_select = sel_q`, and `i_route` is ignored.
- BUSY transitions:
  - A fire with tail = 1 on channel `vc_q`: go to IDLE and increment the counter for `sel_q`.
- Error conditions. Each sets `o_error`; the flag is cleared only by reset.
  - In IDLE: valid with `i_head = 0`.
  - In IDLE: valid head with `i_route` not one-hot (zero or multi-hot). `o_select` stays 0.
  - In BUSY: valid on a channel other than `vc_q`. The flit is not blocked by the controller; `o_select` stays at `sel_q`.
  - In BUSY: valid with `i_head = 1`. `o_select` stays at `sel_q`.
- Counters: saturate at all-ones, never wrap. Each increments exactly once per completed packet.
- Stalls: valid without ready causes no state change.

## Timing
- Reset values:
  - State IDLE.
  - `sel_q`, `vc_q`, `o_busy`, `o_error` all 0.
  - All counters 0.
  - `o_select = 0` unless the inputs present a valid head flit.
- Head flit: zero-cycle path from `i_route` to `o_select`.
- Body and tail flits use the registered `sel_q`.
- `o_busy` is registered: high from the cycle after the head flit fires to the cycle of the tail flit fire, inclusive.
- Back-to-back packets: after the tail fires, a new head may fire in the very next cycle with a different route; no bubble is required.
- Counter update is visible one cycle after the completing fire.
- Reset during BUSY returns to IDLE next cycle. The partial packet is not counted.
- Reset asserted together with a fire: reset wins.

## Structure
- Shared package holds:
  - `tnoc_demux_ctrl_state_e` {IDLE, BUSY}.
  - A one-hot check function `tnoc_is_onehot`, reused by the demux and the mux.
- Natural sub-module: `tnoc_packet_counter` (one saturating counter), instantiated ENTRIES times.
- The controller drives the demux's `i_select` directly. The top level connects `i_valid`/`i_ready` to `flit_in_if.valid`/`flit_in_if.ready` and decodes head/tail/route from `flit_in_if.flit`.

## Test plan
- Single-flit packet, `i_route = 2'b10`, ready = 1 → `o_select = 2'b10` in the same cycle; state stays IDLE; `count[1] = 1` next cycle; `o_busy` never rises.
- 4-flit packet on VC0 to `2'b01`; `i_route` toggled to `2'b10` during the body; ready low for 2 cycles mid-packet → `o_select` stays `2'b01` throughout; `o_busy` high for 3 cycles plus the stall cycles; `count[0] = 1`.
- Tail to output 0 followed immediately by a head to output 1 → `o_select` goes `01` then `10` with no gap cycle; both counters incremented.
- Non-head flit in IDLE; `i_route = 2'b11` on a head flit → `o_select = 0`; `o_error` = 1 and stays 1 until reset.
- Reset asserted mid-packet (after 2 of 4 flits) → next cycle: IDLE, `o_busy = 0`, `sel_q = 0`, counters 0.
- With `COUNTER_WIDTH = 2`, send 5 single-flit packets to output 0 → `count[0]` saturates at 3.
